// File: rtl/spi_ddr_pkg.sv
// spi_ddr_pkg
//   Shared types and pure helpers for the SPI DDR transmit serializer.
//   - lane_mode_e    : x1 / x2 / x4 lane selection (encoding 3 is reserved, behaves as x1)
//   - state_e        : serializer FSM states
//   - slots_per_byte : number of DDR slots (clock cycles) one byte occupies in a mode
//   - norm_mode      : folds the reserved encoding onto X1
//   - lane_mask      : per-lane enable pattern for a mode
//   - slice_slot     : returns {d_p[3:0], d_n[3:0]} for slot idx of a byte
package spi_ddr_pkg;

  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {
    X1 = 2'd0,
    X2 = 2'd1,
    X4 = 2'd2,
    XR = 2'd3
  } lane_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_e;

  // Each clock carries 2*lanes bits, so a byte takes 8/(2*lanes) slots.
  function automatic logic [2:0] slots_per_byte(lane_mode_e m);
    logic [2:0] n;
    case (m)
      X2:      n = 3'd2;
      X4:      n = 3'd1;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic lane_mode_e norm_mode(lane_mode_e m);
    return (m == XR) ? X1 : m;
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask(lane_mode_e m);
    logic [MAX_LANES-1:0] mask;
    case (m)
      X2:      mask = 4'b0011;
      X4:      mask = 4'b1111;
      default: mask = 4'b0001;
    endcase
    return mask;
  endfunction

  // MSB first: shifting the byte left by the bits already sent brings the
  // next bits to the top, where the rising-edge bits are taken before the
  // falling-edge bits. Higher lanes take the more significant bits.
  function automatic logic [7:0] slice_slot(logic [7:0] b, logic [1:0] idx, lane_mode_e m);
    logic [7:0] sh;
    logic [3:0] dp;
    logic [3:0] dn;
    sh = 8'h00;
    dp = 4'h0;
    dn = 4'h0;
    case (m)
      X2: begin
        sh = b << {idx, 2'b00};
        dp = {2'b00, sh[7:6]};
        dn = {2'b00, sh[5:4]};
      end
      X4: begin
        dp = b[7:4];
        dn = b[3:0];
      end
      default: begin
        sh = b << {idx, 1'b0};
        dp = {3'b000, sh[7]};
        dn = {3'b000, sh[6]};
      end
    endcase
    return {dp, dn};
  endfunction

endpackage

// File: rtl/spi_ddr_tx_serializer.sv
// spi_ddr_tx_serializer
//   Slices an incoming byte stream into per-lane DDR bit pairs for the SPI
//   flash output cells, MSB first, in x1/x2/x4 lane modes with no idle slot
//   between back-to-back bytes.
// Ports
//   clk        in   clock (also clk_p of the DDR cells)
//   rst_n      in   asynchronous active-low reset
//   lane_mode  in   lane_mode_e encoding, sampled on the first byte of a frame
//   s_data     in   byte to transmit
//   s_valid    in   s_data valid
//   s_last     in   byte is the last of its frame
//   s_ready    out  serializer can take a byte this cycle
//   d_p        out  per-lane rising half-cycle bit
//   d_n        out  per-lane falling half-cycle bit
//   en         out  per-lane DDR enable (slot carries data)
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the final slot of a frame
//   underrun   out  sticky starvation flag, cleared at next frame start
//   dbg_state  out  current FSM state
//
// Handshake: a byte transfers on a rising clk edge where s_valid and s_ready
// are both 1. s_ready depends only on the slot counter (never on s_valid), and
// is high while the last slot of the current byte is on the outputs, or when
// no byte is in flight, so the next byte follows without a bubble.
module spi_ddr_tx_serializer
  import spi_ddr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           lane_mode,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [MAX_LANES-1:0] d_p,
  output logic [MAX_LANES-1:0] d_n,
  output logic [MAX_LANES-1:0] en,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output state_e               dbg_state
);

  state_e     state_q;
  lane_mode_e mode_q;
  logic [7:0] shreg;
  logic [1:0] idx_q;       // index of the next slot to put on the outputs
  logic [2:0] slots_left;  // slots of the current byte not yet finished, including the one shown
  logic       last_q;

  logic       accept;
  logic       frame_end;
  logic       new_frame;
  lane_mode_e mode_use;
  logic [7:0] slice_new;
  logic [7:0] slice_cur;

  assign s_ready   = (slots_left == 3'd0) | (slots_left == 3'd1);
  assign dbg_state = state_q;

  always_comb begin
    accept    = s_valid & s_ready;
    // The final slot of the frame is on the outputs right now.
    frame_end = (state_q == SHIFT) && (slots_left == 3'd1) && last_q;
    // A byte accepted while idle, or exactly as the previous frame ends,
    // opens a new frame and resamples the lane mode.
    new_frame = accept && ((state_q == IDLE) || frame_end);
    mode_use  = new_frame ? norm_mode(lane_mode_e'(lane_mode)) : mode_q;
    slice_new = slice_slot(s_data, 2'd0, mode_use);
    slice_cur = slice_slot(shreg, idx_q, mode_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= X1;
      shreg      <= 8'h00;
      idx_q      <= 2'd0;
      slots_left <= 3'd0;
      last_q     <= 1'b0;
      d_p        <= '0;
      d_n        <= '0;
      en         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else if (accept) begin
      state_q    <= SHIFT;
      mode_q     <= mode_use;
      shreg      <= s_data;
      idx_q      <= 2'd1;
      slots_left <= slots_per_byte(mode_use);
      last_q     <= s_last;
      d_p        <= slice_new[7:4];
      d_n        <= slice_new[3:0];
      en         <= lane_mask(mode_use);
      busy       <= 1'b1;
      done       <= frame_end;
      if (new_frame) begin
        underrun <= 1'b0;
      end
    end else if ((state_q == SHIFT) && (slots_left > 3'd1)) begin
      d_p        <= slice_cur[7:4];
      d_n        <= slice_cur[3:0];
      en         <= lane_mask(mode_q);
      idx_q      <= idx_q + 2'd1;
      slots_left <= slots_left - 3'd1;
      done       <= 1'b0;
    end else if (state_q == SHIFT) begin
      // Last slot of the byte has been shown and nothing follows it.
      d_p        <= '0;
      d_n        <= '0;
      en         <= '0;
      slots_left <= 3'd0;
      if (last_q) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        state_q  <= STALL;
        underrun <= 1'b1;
        done     <= 1'b0;
      end
    end else begin
      d_p  <= '0;
      d_n  <= '0;
      en   <= '0;
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_ddr_tx_serializer.sv
// tb_spi_ddr_tx_serializer
//   Directed scenarios with literal expectations plus randomized frames,
//   all checked every cycle against a slot-queue model of the serializer.
module tb_spi_ddr_tx_serializer;
  import spi_ddr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] lane_mode;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [3:0] d_p;
  logic [3:0] d_n;
  logic [3:0] en;
  logic       busy;
  logic       done;
  logic       underrun;
  state_e     dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_ddr_tx_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lane_mode (lane_mode),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .d_p       (d_p),
    .d_n       (d_n),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // exp_q holds slots still to be shown, each packed {final, en, d_p, d_n}.
  // cur is what the outputs must show now.
  logic [12:0] exp_q[$];
  logic [12:0] cur;
  bit          m_open;
  bit          m_done;
  bit          m_busy;
  bit          m_under;
  logic [1:0]  m_mode;

  function automatic int n_slots(logic [1:0] mode);
    if (mode == 2'd1) return 2;
    if (mode == 2'd2) return 1;
    return 4;
  endfunction

  function automatic logic [12:0] mk_slot(logic [7:0] b, int i, logic [1:0] mode, bit fin);
    logic [3:0] dp;
    logic [3:0] dn;
    logic [3:0] e;
    logic [2:0] p;
    dp = 4'h0;
    dn = 4'h0;
    if (mode == 2'd1) begin
      p = 3'(7 - 4 * i); dp[1] = b[p];
      p = 3'(6 - 4 * i); dp[0] = b[p];
      p = 3'(5 - 4 * i); dn[1] = b[p];
      p = 3'(4 - 4 * i); dn[0] = b[p];
      e = 4'b0011;
    end else if (mode == 2'd2) begin
      dp = b[7:4];
      dn = b[3:0];
      e  = 4'b1111;
    end else begin
      p = 3'(7 - 2 * i); dp[0] = b[p];
      p = 3'(6 - 2 * i); dn[0] = b[p];
      e = 4'b0001;
    end
    return {fin, e, dp, dn};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    int n;
    if (!rst_n) begin
      exp_q.delete();
      cur     = 13'h0;
      m_open  = 1'b0;
      m_done  = 1'b0;
      m_busy  = 1'b0;
      m_under = 1'b0;
      m_mode  = 2'd0;
    end else begin
      acc    = s_valid && (exp_q.size() == 0);
      m_done = cur[12];
      if (cur[12]) m_open = 1'b0;
      if (acc) begin
        if (!m_open) begin
          m_mode  = (lane_mode == 2'd3) ? 2'd0 : lane_mode;
          m_under = 1'b0;
        end
        m_open = 1'b1;
        n = n_slots(m_mode);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_slot(s_data, i, m_mode, s_last && (i == n - 1)));
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else begin
        cur = 13'h0;
        if (m_open) m_under = 1'b1;
      end
      m_busy = m_open;
    end
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cyc d_p", 32'(d_p), 32'(cur[7:4]));
      check("cyc d_n", 32'(d_n), 32'(cur[3:0]));
      check("cyc en", 32'(en), 32'(cur[11:8]));
      check("cyc done", 32'(done), 32'(m_done));
      check("cyc busy", 32'(busy), 32'(m_busy));
      check("cyc underrun", 32'(underrun), 32'(m_under));
      check("cyc s_ready", 32'(s_ready), 32'(exp_q.size() == 0));
    end
  end

  // ---------------- driver ----------------
  // Entered and left on a falling edge; returns on the falling edge right
  // after the byte was accepted, so slot 0 is on the outputs.
  task automatic send(logic [7:0] b, logic l, logic [1:0] mode);
    int t;
    t = 0;
    lane_mode = mode;
    s_data    = b;
    s_last    = l;
    s_valid   = 1'b1;
    while (!s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send timeout: s_ready=%0b, required 1 within 40 cycles", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    s_last  = 1'($urandom);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode;
    int len;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    s_last    = 1'b0;
    lane_mode = 2'd0;
    repeat (3) @(negedge clk);
    check("rst d_p", 32'(d_p), 0);
    check("rst en", 32'(en), 0);
    check("rst busy", 32'(busy), 0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    check("rst s_ready", 32'(s_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: X1, 0xA5 last
    send(8'hA5, 1'b1, 2'd0);
    check("t1 s0", 32'({d_p[0], d_n[0], en}), 32'({2'b10, 4'b0001}));
    s_valid = 1'b0;
    @(negedge clk); check("t1 s1", 32'({d_p[0], d_n[0]}), 32'(2'b10));
    @(negedge clk); check("t1 s2", 32'({d_p[0], d_n[0]}), 32'(2'b01));
    @(negedge clk); check("t1 s3", 32'({d_p[0], d_n[0], en}), 32'({2'b01, 4'b0001}));
    @(negedge clk); check("t1 done", 32'({done, busy, en}), 32'({2'b10, 4'b0000}));
    @(negedge clk); check("t1 done pulse", 32'(done), 0);

    // 2: X4, 0x3C then 0x81 last, no bubble
    send(8'h3C, 1'b0, 2'd2);
    check("t2 b0", 32'({d_p, d_n, en}), 32'h3CF);
    send(8'h81, 1'b1, 2'd2);
    check("t2 b1", 32'({d_p, d_n, en}), 32'h81F);
    s_valid = 1'b0;
    @(negedge clk); check("t2 done", 32'({done, en}), 32'h10);

    // 3: X2, 0xB4 last
    send(8'hB4, 1'b1, 2'd1);
    check("t3 s0", 32'({d_p, d_n, en}), 32'({4'b0010, 4'b0011, 4'b0011}));
    s_valid = 1'b0;
    @(negedge clk); check("t3 s1", 32'({d_p, d_n, en}), 32'({4'b0001, 4'b0000, 4'b0011}));
    @(negedge clk); check("t3 done", 32'(done), 1);

    // 4: underrun
    send(8'hFF, 1'b0, 2'd0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4 stall", 32'({en, underrun, busy}), 32'({4'b0000, 2'b11}));
    end
    send(8'h00, 1'b1, 2'd0);
    check("t4 resume", 32'({en, d_p, underrun}), 32'({4'b0001, 4'b0000, 1'b1}));
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); check("t4 done", 32'({done, busy, underrun}), 32'(3'b101));
    @(negedge clk); check("t4 sticky", 32'(underrun), 1);

    // 5: mode change mid-frame ignored
    send(8'hF0, 1'b0, 2'd0);
    check("t5 clear", 32'(underrun), 0);
    lane_mode = 2'd2;
    s_valid   = 1'b0;
    send(8'h0F, 1'b1, 2'd2);
    check("t5 mode kept", 32'({en, d_p, d_n}), 32'({4'b0001, 8'h00}));
    idle(6);

    // 6: async reset mid-byte
    send(8'hA5, 1'b0, 2'd0);
    s_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6 outs", 32'({d_p, d_n, en, busy, done, underrun}), 0);
    check("t6 state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    check("t6 ready", 32'({s_ready, busy}), 32'(2'b10));
    @(negedge clk);

    // random frames
    repeat (80) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        send(8'($urandom), 1'(j == len - 1), (j == 0) ? 2'(mode) : 2'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 6));
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
